// File: rtl/ushift_pkg.sv
// Shared constants for the universal shift register:
// mode encodings and FSM state type.
package ushift_pkg;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROTL  = 3'b100;
    localparam logic [2:0] M_ROTR  = 3'b101;
    localparam logic [2:0] M_BROTL = 3'b110;
    localparam logic [2:0] M_BROTR = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ushift_reg.sv
// Universal shift register: load, shift, rotate and
// multi-cycle burst rotate with busy/done handshake.
module ushift_reg
    import ushift_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int              AW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    amt,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done,
    output logic             changed
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    rem_q, rem_d;
    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             changed_q, changed_d;

    logic [WIDTH-1:0] rotl, rotr;

    assign rotl = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
    assign rotr = {data_q[0], data_q[WIDTH-1:1]};

    always_comb begin
        data_d  = data_q;
        rem_d   = rem_q;
        state_d = state_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (clr) begin
            data_d  = RST_VAL;
            rem_d   = '0;
            state_d = ST_IDLE;
        end else if (state_q == ST_RUN) begin
            data_d = dir_q ? rotr : rotl;
            rem_d  = rem_q - AW'(1);
            if (rem_q == AW'(1)) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end else if (en) begin
            unique case (mode)
                M_HOLD: data_d = data_q;
                M_LOAD: data_d = d;
                M_SHL:  data_d = {data_q[WIDTH-2:0], sin_r};
                M_SHR:  data_d = {sin_l, data_q[WIDTH-1:1]};
                M_ROTL: data_d = rotl;
                M_ROTR: data_d = rotr;
                M_BROTL, M_BROTR: begin
                    // mode[0] selects rotate-right
                    dir_d = mode[0];
                    if (amt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        data_d = mode[0] ? rotr : rotl;
                        if (amt == AW'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            rem_d   = amt - AW'(1);
                            state_d = ST_RUN;
                        end
                    end
                end
            endcase
        end
        changed_d = (data_d != data_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= RST_VAL;
            rem_q     <= '0;
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            done_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            rem_q     <= rem_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            done_q    <= done_d;
            changed_q <= changed_d;
        end
    end

    assign q       = data_q;
    assign sout_l  = data_q[WIDTH-1];
    assign sout_r  = data_q[0];
    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_ushift_reg.sv
// Directed bench for ushift_reg, WIDTH=8, RST_VAL=A5.
module tb_ushift_reg;
    import ushift_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, clr, en, sin_r, sin_l;
    logic [2:0] mode;
    logic [7:0] d;
    logic [2:0] amt;
    logic [7:0] q;
    logic       sout_l, sout_r, busy, done, changed;

    int checks = 0;
    int errors = 0;

    ushift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en),
        .mode(mode), .d(d), .amt(amt),
        .sin_r(sin_r), .sin_l(sin_l), .q(q),
        .sout_l(sout_l), .sout_r(sout_r),
        .busy(busy), .done(done), .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        en = 1'b1; mode = M_LOAD; d = v;
        step();
        en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; en = 1'b0;
        mode = M_HOLD; d = '0; amt = '0;
        sin_r = 1'b0; sin_l = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if (q !== 8'hA5) begin
            errors++; $display("FAIL reset_q: got %h want a5", q);
        end
        checks++;
        if ({busy, done, changed} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {busy, done, changed});
        end
        checks++;
        if ({sout_l, sout_r} !== 2'b11) begin
            errors++;
            $display("FAIL reset_sout: got %b want 11",
                     {sout_l, sout_r});
        end
        load(8'h3C);
        checks++;
        if (q !== 8'h3C || changed !== 1'b1) begin
            errors++;
            $display("FAIL load: got q=%h ch=%b want 3c/1",
                     q, changed);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (q !== 8'hA5 || changed !== 1'b1) begin
            errors++;
            $display("FAIL clr: got q=%h ch=%b want a5/1",
                     q, changed);
        end
        step();
        checks++;
        if (changed !== 1'b0) begin
            errors++;
            $display("FAIL hold_changed: got %b want 0", changed);
        end
    endtask

    task automatic test_shift();
        load(8'b1000_0001);
        en = 1'b1; mode = M_SHL; sin_r = 1'b1;
        step();
        checks++;
        if (q !== 8'b0000_0011) begin
            errors++; $display("FAIL shl: got %b want 00000011", q);
        end
        mode = M_SHR; sin_l = 1'b0; sin_r = 1'b0;
        step();
        en = 1'b0;
        checks++;
        if (q !== 8'b0000_0001 || sout_r !== 1'b1 || sout_l !== 1'b0) begin
            errors++;
            $display("FAIL shr: got q=%b sr=%b sl=%b want 00000001/1/0",
                     q, sout_r, sout_l);
        end
    endtask

    task automatic test_rotate();
        load(8'h81);
        en = 1'b1; mode = M_ROTL;
        step();
        checks++;
        if (q !== 8'h03) begin
            errors++; $display("FAIL rotl: got %h want 03", q);
        end
        mode = M_ROTR;
        step(); step();
        en = 1'b0;
        checks++;
        if (q !== 8'hC0) begin
            errors++; $display("FAIL rotr2: got %h want c0", q);
        end
    endtask

    task automatic test_burst();
        int  busy_cnt;
        bit  seen_done;
        bit  overlap;
        load(8'h01);
        en = 1'b1; mode = M_BROTL; amt = 3'd5;
        step();
        busy_cnt = 0; seen_done = 0; overlap = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            if (busy && done) overlap = 1;
            if (busy) busy_cnt++;
            if (done) begin
                seen_done = 1;
                break;
            end
            en = i[0]; mode = M_LOAD; d = 8'hFF; amt = 3'd2;
        end
        en = 1'b0;
        checks++;
        if (!seen_done) begin
            errors++; $display("FAIL burst_done: got none want pulse");
        end
        checks++;
        if (busy_cnt != 4) begin
            errors++;
            $display("FAIL burst_busy: got %0d cycles want 4", busy_cnt);
        end
        checks++;
        if (q !== 8'h20) begin
            errors++; $display("FAIL burst_q: got %h want 20", q);
        end
        checks++;
        if (overlap) begin
            errors++; $display("FAIL burst_overlap: got 1 want 0");
        end
        step();
        checks++;
        if (done !== 1'b0 || q !== 8'h20) begin
            errors++;
            $display("FAIL burst_after: got done=%b q=%h want 0/20",
                     done, q);
        end
    endtask

    task automatic test_burst_edge();
        load(8'h01);
        step();
        en = 1'b1; mode = M_BROTL; amt = 3'd0;
        step();
        en = 1'b0;
        checks++;
        if ({done, busy, changed} !== 3'b100 || q !== 8'h01) begin
            errors++;
            $display("FAIL amt0: got dbc=%b q=%h want 100/01",
                     {done, busy, changed}, q);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL amt0_pulse: got %b want 0", done);
        end
        en = 1'b1; mode = M_BROTR; amt = 3'd1;
        step();
        en = 1'b0;
        checks++;
        if (q !== 8'h80 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL amt1: got q=%h d=%b b=%b want 80/1/0",
                     q, done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h80) begin
            errors++;
            $display("FAIL amt1_after: got q=%h d=%b b=%b want 80/0/0",
                     q, done, busy);
        end
    endtask

    task automatic test_abort();
        bit bad_done;
        load(8'h01);
        en = 1'b1; mode = M_BROTL; amt = 3'd7;
        step();
        en = 1'b0;
        step(); step();
        checks++;
        if (busy !== 1'b1 || q !== 8'h08) begin
            errors++;
            $display("FAIL abort_pre: got b=%b q=%h want 1/08", busy, q);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b0 ||
            changed !== 1'b1) begin
            errors++;
            $display("FAIL abort_clr: got q=%h b=%b d=%b c=%b want a5/0/0/1",
                     q, busy, done, changed);
        end
        bad_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) bad_done = 1;
        end
        checks++;
        if (bad_done) begin
            errors++; $display("FAIL abort_clr_quiet: got activity want none");
        end
        load(8'h01);
        en = 1'b1; mode = M_BROTL; amt = 3'd7;
        step();
        en = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'hA5 || {busy, done, changed} !== 3'b000) begin
            errors++;
            $display("FAIL abort_rst: got q=%h bdc=%b want a5/000",
                     q, {busy, done, changed});
        end
        bad_done = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done || busy) bad_done = 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) bad_done = 1;
        end
        checks++;
        if (bad_done || q !== 8'hA5) begin
            errors++;
            $display("FAIL abort_rst_quiet: got q=%h act=%b want a5/0",
                     q, bad_done);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_rotate();
        test_burst();
        test_burst_edge();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
